// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Op encodings follow funct3 of the M extension.
package muldiv_pkg;

  localparam int MD_XLEN  = 32;
  localparam int MD_STEPS = 32;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUOT  = 32'h8000_0000;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } md_state_e;

  function automatic logic a_signed(md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU,
                      MD_DIV, MD_REM};
  endfunction

  function automatic logic b_signed(md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// EX-stage <-> multiply/divide sequencer handshake bundle.
// master = EX stage, slave = sequencer.
interface muldiv_seq_if;
  import muldiv_pkg::*;

  logic        start;
  md_op_e      op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        stall_req;

  modport master (
    output start, op, rs1, rs2, flush,
    input  busy, done, result, stall_req
  );

  modport slave (
    input  start, op, rs1, rs2, flush,
    output busy, done, result, stall_req
  );

endinterface

// File: rtl/muldiv_addsub33.sv
// 33-bit add/subtract with carry out; carry=1 on subtract means a >= b.
// Shared by the multiply accumulate and the divide trial subtraction.
module muldiv_addsub33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] sum,
  output logic        cout
);

  logic [33:0] full;

  assign full = {1'b0, a}
              + {1'b0, b ^ {33{sub}}}
              + {33'd0, sub};
  assign sum  = full[32:0];
  assign cout = full[33];

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M sequencer: shift-add multiply, restoring divide,
// and a single-cycle path for divide-by-zero and signed overflow.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int STEPS = MD_STEPS
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave bus
);

  localparam int CW = $clog2(STEPS);

  md_state_e         state;
  md_op_e            op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   mag;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   result_q;
  logic [CW-1:0]     cnt;
  logic              neg_q;
  logic              busy_q;
  logic              done_q;

  logic              accept;
  logic              is_div;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic              div0;
  logic              ovf;
  logic              fast;
  logic [XLEN-1:0]   fast_res;
  logic [XLEN:0]     add_a;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     step;
  logic              cout;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   fix_res;

  assign accept = bus.start & ~bus.flush;
  assign is_div = op_q[2];

  assign neg_a = a_signed(op_q) & a_q[XLEN-1];
  assign neg_b = b_signed(op_q) & b_q[XLEN-1];
  assign abs_a = neg_a ? -a_q : a_q;
  assign abs_b = neg_b ? -b_q : b_q;

  assign div0 = (bus.rs2 == '0);
  assign ovf  = (bus.rs1 == OVF_QUOT) && (bus.rs2 == '1);

  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
    unique case (1'b1)
      div0 && (bus.op inside {MD_DIV, MD_DIVU}): begin
        fast     = 1'b1;
        fast_res = DIV0_QUOT;
      end
      div0 && (bus.op inside {MD_REM, MD_REMU}): begin
        fast     = 1'b1;
        fast_res = bus.rs1;
      end
      ovf && (bus.op == MD_DIV): begin
        fast     = 1'b1;
        fast_res = OVF_QUOT;
      end
      ovf && (bus.op == MD_REM): begin
        fast     = 1'b1;
        fast_res = '0;
      end
      default: ;
    endcase
  end

  // Divide shifts the next dividend bit into the remainder before
  // the trial subtract; multiply adds the multiplicand into hi.
  assign add_a = is_div ? {hi, lo[XLEN-1]} : {1'b0, hi};

  muldiv_addsub33 u_addsub (
    .a    (add_a),
    .b    ({1'b0, mag}),
    .sub  (is_div),
    .sum  (sum),
    .cout (cout)
  );

  assign step = lo[0] ? sum : {1'b0, hi};

  assign prod     = {hi, lo};
  assign prod_fix = neg_q ? -prod : prod;

  always_comb begin
    fix_res = '0;
    unique case (op_q)
      MD_MUL:    fix_res = prod_fix[XLEN-1:0];
      MD_MULH,
      MD_MULHSU,
      MD_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
      MD_DIV,
      MD_DIVU:   fix_res = neg_q ? -lo : lo;
      MD_REM,
      MD_REMU:   fix_res = neg_q ? -hi : hi;
      default:   fix_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= MD_MUL;
      a_q      <= '0;
      b_q      <= '0;
      mag      <= '0;
      hi       <= '0;
      lo       <= '0;
      result_q <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_q <= bus.op;
            a_q  <= bus.rs1;
            b_q  <= bus.rs2;
            if (fast) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
              state    <= S_DONE;
            end else begin
              busy_q <= 1'b1;
              state  <= S_PREP;
            end
          end
        end
        S_PREP: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            hi  <= '0;
            cnt <= CW'(STEPS - 1);
            if (op_q inside {MD_REM, MD_REMU})
              neg_q <= neg_a;
            else
              neg_q <= neg_a ^ neg_b;
            if (is_div) begin
              lo  <= abs_a;
              mag <= abs_b;
            end else begin
              lo  <= abs_b;
              mag <= abs_a;
            end
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            if (is_div) begin
              hi <= cout ? sum[XLEN-1:0]
                         : add_a[XLEN-1:0];
              lo <= {lo[XLEN-2:0], cout};
            end else begin
              hi <= step[XLEN:1];
              lo <= {step[0], lo[XLEN-1:1]};
            end
            cnt <= cnt - CW'(1);
            if (cnt == '0)
              state <= S_FIX;
          end
        end
        S_FIX: begin
          busy_q <= 1'b0;
          if (bus.flush) begin
            state <= S_IDLE;
          end else begin
            result_q <= fix_res;
            done_q   <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.stall_req = ~rst &
    ((bus.start & (state == S_IDLE)) | busy_q);

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised + directed bench for muldiv_seq against a
// plain-arithmetic RV32M reference model.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] last_res;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic logic [31:0] ref_res(
    input md_op_e op, input logic [31:0] a,
    input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    logic ov;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MD_MUL:    begin p = sa * sb; return p[31:0];  end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin p = ua * ub; return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ov) return 32'h8000_0000;
        return ia / ib;
      end
      MD_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      MD_REM: begin
        if (b == 0) return a;
        if (ov) return 32'd0;
        return ia % ib;
      end
      MD_REMU: begin
        if (b == 0) return a;
        return a % b;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_fast(input md_op_e op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    bit sgn;
    sgn = (op == MD_DIV) || (op == MD_REM);
    if (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}
        && b == 0) return 1'b1;
    return sgn && a == 32'h8000_0000
               && b == 32'hFFFF_FFFF;
  endfunction

  // Called at edge+1 of cycle 0; returns at edge+1 of the
  // cycle after done with start low.
  task automatic run_op(input md_op_e op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input string tag);
    logic [31:0] exp;
    int lat, got, bad_b, bad_s;
    bit f;
    exp   = ref_res(op, a, b);
    f     = is_fast(op, a, b);
    lat   = f ? 1 : 35;
    got   = -1;
    bad_b = 0;
    bad_s = 0;
    bus.op    = op;
    bus.rs1   = a;
    bus.rs2   = b;
    bus.start = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      #1;
      if (bus.busy !== (!f && c >= 1 && c < lat)) bad_b++;
      if (bus.stall_req !== (c < lat)) bad_s++;
      if (bus.done === 1'b1) begin
        got = c;
        break;
      end
      @(posedge clk);
      #1;
      bus.rs1 = $urandom;
      bus.rs2 = $urandom;
      bus.op  = md_op_e'($urandom_range(0, 7));
    end
    check({tag, " lat"}, got, lat);
    check({tag, " res"}, bus.result, exp);
    check({tag, " busy"}, bad_b, 0);
    check({tag, " stall"}, bad_s, 0);
    last_res = exp;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int n_done;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = MD_MUL;
    bus.rs1   = '0;
    bus.rs2   = '0;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    #1;
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst result", bus.result, 0);
    check("rst stall", bus.stall_req, 0);
    bus.start = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(MD_MUL,    32'd7, 32'hFFFF_FFFD, "mul");
    run_op(MD_MULH,   32'h8000_0000, 32'h8000_0000, "mulh");
    run_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run_op(MD_DIV,    32'hFFFF_FFF9, 32'd2, "div");
    run_op(MD_REM,    32'hFFFF_FFF9, 32'd2, "rem");
    run_op(MD_DIVU,   32'd100, 32'd7, "divu");
    run_op(MD_REMU,   32'd100, 32'd7, "remu");
    run_op(MD_DIVU,   32'h1234, 32'd0, "divu0");
    run_op(MD_REM,    32'd5, 32'd0, "rem0");
    run_op(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, "divovf");
    run_op(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, "removf");

    n_done = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.done || bus.busy) n_done++;
      @(posedge clk);
      #1;
    end
    check("held start reissue", n_done, 0);

    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = MD_MUL;
    bus.rs1   = 32'd3;
    bus.rs2   = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    check("flush idle busy", bus.busy, 0);
    check("flush idle done", bus.done, 0);
    @(posedge clk);
    #1;

    n_done    = 0;
    bus.op    = MD_DIVU;
    bus.rs1   = 32'd1000;
    bus.rs2   = 32'd3;
    bus.start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.done) n_done++;
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    bus.start = 1'b0;
    #1;
    if (bus.done) n_done++;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    #1;
    if (bus.done) n_done++;
    check("flush busy", bus.busy, 0);
    check("flush no done", n_done, 0);
    check("flush result", bus.result, last_res);
    @(posedge clk);
    #1;
    run_op(MD_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, "flush restart");

    bus.op    = MD_REMU;
    bus.rs1   = 32'hCAFE_F00D;
    bus.rs2   = 32'd77;
    bus.start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
    end
    rst       = 1'b1;
    bus.start = 1'b0;
    #1;
    check("midrst stall", bus.stall_req, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst busy", bus.busy, 0);
    check("midrst done", bus.done, 0);
    check("midrst result", bus.result, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      md_op_e op;
      op = md_op_e'($urandom_range(0, 7));
      run_op(op, pick(), pick(), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
